// File: rtl/shadow_reg_pkg.sv
// shadow_reg_pkg: shared types and constants for the shadowed control register.
// Holds ctrl_t, the controller state encoding and the committed reset value.
package shadow_reg_pkg;

  typedef struct packed {
    logic [1:0] a;
    logic [2:0] b;
  } ctrl_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STAGED = 1'b1
  } shadow_state_e;

  localparam ctrl_t CTRL_RESVAL = '{a: 2'b11, b: 3'b000};

endpackage

// File: rtl/shadow_reg_store.sv
// shadow_reg_store: committed/inverted-shadow register pair with flip injection.
// Ports: clk_i, rst_ni (sync, low), commit_i, wd_i, flip_i -> q_o, err_storage_o.
module shadow_reg_store
  import shadow_reg_pkg::*;
#(
  parameter int unsigned    DW     = 5,
  parameter logic [DW-1:0]  RESVAL = CTRL_RESVAL
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          commit_i,
  input  logic [DW-1:0] wd_i,
  input  logic [DW-1:0] flip_i,
  output logic [DW-1:0] q_o,
  output logic          err_storage_o
);

  logic [DW-1:0] committed;
  logic [DW-1:0] shadow;
  logic          mism;

  assign mism = (committed != ~shadow);
  assign q_o  = committed;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      committed <= RESVAL;
      shadow    <= ~RESVAL;
    end else if (commit_i) begin
      committed <= wd_i;
      shadow    <= ~wd_i;
    end else begin
      shadow    <= shadow ^ flip_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_storage_o <= 1'b0;
    end else begin
`ifdef SHADOW_REG_STICKY_ERR_EN
      err_storage_o <= err_storage_o | mism;
`else
      err_storage_o <= mism;
`endif
    end
  end

endmodule

// File: rtl/shadow_reg_ctrl.sv
// shadow_reg_ctrl: two-phase write controller; commits only on matching double write.
// Ports: bus we/wd/re, shadow_flip_i -> q_o, phase_o, err_update_o, err_storage_o, timeout_o.
// Optional: SHADOW_REG_STICKY_ERR_EN makes error outputs latch until reset.
module shadow_reg_ctrl
  import shadow_reg_pkg::*;
#(
  parameter int unsigned    DW      = 5,
  parameter logic [DW-1:0]  RESVAL  = CTRL_RESVAL,
  parameter int unsigned    TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic [DW-1:0] shadow_flip_i,
  output logic [DW-1:0] q_o,
  output logic          phase_o,
  output logic          err_update_o,
  output logic          err_storage_o,
  output logic          timeout_o
);

  localparam logic [0:0] IDLE   = ST_IDLE;
  localparam logic [0:0] STAGED = ST_STAGED;

  localparam int unsigned CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CMAX = '1;
  localparam bit TO_EN = (TIMEOUT > 0);

  logic [0:0]    state;
  logic [DW-1:0] staged;
  logic [CW-1:0] cnt;
  logic          commit;
  logic          upd_err;

  assign phase_o = (state == STAGED);
  assign commit  = phase_o && we_i && (wd_i == staged);
  assign upd_err = phase_o && we_i && (wd_i != staged);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      staged    <= '0;
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (we_i) begin
            staged <= wd_i;
            cnt    <= '0;
            state  <= STAGED;
          end
        end
        STAGED: begin
          // a write always wins over a same-cycle read
          if (we_i || re_i) begin
            state <= IDLE;
          end else if (TO_EN && cnt == CLAST) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_update_o <= 1'b0;
    end else begin
`ifdef SHADOW_REG_STICKY_ERR_EN
      err_update_o <= err_update_o | upd_err;
`else
      err_update_o <= upd_err;
`endif
    end
  end

  shadow_reg_store #(
    .DW     (DW),
    .RESVAL (RESVAL)
  ) u_store (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .commit_i      (commit),
    .wd_i          (wd_i),
    .flip_i        (shadow_flip_i),
    .q_o           (q_o),
    .err_storage_o (err_storage_o)
  );

endmodule
